// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - op codes and FSM encoding shared by the ALU arbiter files
package alu_arbiter_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - purely combinational ALU evaluating one operation
module alu_core
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ctrl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  // Decode the op code; unknown codes yield result 0 and flag err.
  always_comb begin
    result = '0;
    err    = 1'b0;
    case (ctrl)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, (a < b)};
      default: err    = 1'b1;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between two requesters
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_ctrl,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic             rsp1_err
);

  state_t           state;
  state_t           state_next;
  logic             ptr;        // port that wins when both request
  logic             owner;      // port whose op is in flight
  logic             gnt0;
  logic             gnt1;
  logic             accept;
  logic             rsp_done;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       ctrl_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             err_q;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_err;

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .a      (a_q),
    .b      (b_q),
    .ctrl   (ctrl_q),
    .result (alu_result),
    .zero   (alu_zero),
    .err    (alu_err)
  );

  // Grant only in IDLE and never while reset is asserted; contention goes to ptr.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        gnt0 = ~ptr;
        gnt1 = ptr;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign accept     = gnt0 | gnt1;
  assign rsp_done   = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);

  // Next-state logic for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Capture the granted op, latch the ALU result in EXEC, rotate priority on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= 1'b0;
      owner  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      ctrl_q <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        owner  <= gnt1;
        a_q    <= gnt1 ? req1_a    : req0_a;
        b_q    <= gnt1 ? req1_b    : req0_b;
        ctrl_q <= gnt1 ? req1_ctrl : req0_ctrl;
      end
      if (state == EXEC) begin
        res_q  <= alu_result;
        zero_q <= alu_zero;
        err_q  <= alu_err;
      end
      if (rsp_done) ptr <= ~owner;
    end
  end

  assign rsp0_valid  = (state == RESP) && !owner;
  assign rsp1_valid  = (state == RESP) && owner;
  assign rsp0_result = res_q;
  assign rsp1_result = res_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_zero   = zero_q;
  assign rsp0_err    = err_q;
  assign rsp1_err    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter against a reference model
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]   req0_ctrl = '0, req1_ctrl = '0;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [W-1:0] rsp0_result, rsp1_result;
  logic         rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           port;
    logic [W-1:0] res;
    logic         zero;
    logic         err;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ptr_m = 0;
  bit   prev_rst = 1'b1;
  bit   auto0 = 1'b0, auto1 = 1'b0;
  int   load_pct = 100;
  int   rdy_pct0 = 100, rdy_pct1 = 100;

  always @(posedge clk) cyc++;

  // Reference: results computed with wide unsigned arithmetic and taken modulo 2^W.
  function automatic exp_t ref_op(int port, logic [W-1:0] a, logic [W-1:0] b, logic [3:0] c, int acc);
    exp_t e;
    longint unsigned m  = 64'd1 << W;
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint unsigned r;
    case (c)
      4'd0:    r = ua & ub;
      4'd1:    r = ua | ub;
      4'd2:    r = (ua + ub) % m;
      4'd6:    r = (ua + m - ub) % m;
      4'd7:    r = (ua < ub) ? 64'd1 : 64'd0;
      default: r = 64'd0;
    endcase
    e.port = port;
    e.res  = r[W-1:0];
    e.zero = (r == 64'd0);
    e.err  = !(c inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7});
    e.acc  = acc;
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_req(int p, logic [3:0] c, logic [W-1:0] a, logic [W-1:0] b);
    if (p == 0) begin
      req0_valid = 1'b1; req0_ctrl = c; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_ctrl = c; req1_a = a; req1_b = b;
    end
  endtask

  task automatic rand_req(int p);
    logic [3:0]   legal [5] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT};
    logic [3:0]   c;
    logic [W-1:0] a, b;
    int           r = $urandom_range(9);
    c = (r < 9) ? legal[r % 5] : 4'($urandom);
    a = $urandom_range(1) ? W'($urandom) : W'($urandom_range(3));
    b = $urandom_range(1) ? W'($urandom) : W'($urandom_range(3));
    set_req(p, c, a, b);
  endtask

  // One clock: note accepted ops at negedge, then update inputs just after posedge.
  task automatic cycle();
    bit h0, h1;
    @(negedge clk);
    h0 = req0_valid && req0_ready && !rst;
    h1 = req1_valid && req1_ready && !rst;
    if (h0) q.push_back(ref_op(0, req0_a, req0_b, req0_ctrl, cyc));
    if (h1) q.push_back(ref_op(1, req1_a, req1_b, req1_ctrl, cyc));
    @(posedge clk);
    #1;
    if (h0) req0_valid = 1'b0;
    if (h1) req1_valid = 1'b0;
    rsp0_ready = ($urandom_range(99) < rdy_pct0);
    rsp1_ready = ($urandom_range(99) < rdy_pct1);
    if (auto0 && !req0_valid && $urandom_range(99) < load_pct) rand_req(0);
    if (auto1 && !req1_valid && $urandom_range(99) < load_pct) rand_req(1);
  endtask

  task automatic drain(int maxc);
    int n = 0;
    while ((q.size() != 0 || req0_valid || req1_valid) && n < maxc) begin
      cycle();
      n++;
    end
    if (n >= maxc) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  // Monitor: grant, response ownership/latency and payload compared every cycle.
  initial begin
    bit idle;
    int g, own;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        q.delete();
        ptr_m    = 0;
        prev_rst = 1'b1;
      end else begin
        if (prev_rst) begin
          chk("rst_rsp0_valid", rsp0_valid, 0);
          chk("rst_rsp1_valid", rsp1_valid, 0);
          chk("rst_rsp0_result", rsp0_result, 0);
          chk("rst_rsp1_result", rsp1_result, 0);
          chk("rst_zero", {rsp0_zero, rsp1_zero}, 0);
          chk("rst_err", {rsp0_err, rsp1_err}, 0);
          prev_rst = 1'b0;
        end
        idle = (q.size() == 0) || (q[0].acc == cyc);
        g = -1;
        if (idle) begin
          if (req0_valid && req1_valid) g = ptr_m;
          else if (req0_valid)          g = 0;
          else if (req1_valid)          g = 1;
        end
        chk("req0_ready", req0_ready, (g == 0));
        chk("req1_ready", req1_ready, (g == 1));
        own = -1;
        if (q.size() != 0 && cyc >= q[0].acc + 2) own = q[0].port;
        chk("rsp0_valid", rsp0_valid, (own == 0));
        chk("rsp1_valid", rsp1_valid, (own == 1));
        if (own == 0 && rsp0_valid) begin
          chk("rsp0_result", rsp0_result, q[0].res);
          chk("rsp0_zero", rsp0_zero, q[0].zero);
          chk("rsp0_err", rsp0_err, q[0].err);
          if (rsp0_ready) begin
            void'(q.pop_front());
            ptr_m = 1;
          end
        end else if (own == 1 && rsp1_valid) begin
          chk("rsp1_result", rsp1_result, q[0].res);
          chk("rsp1_zero", rsp1_zero, q[0].zero);
          chk("rsp1_err", rsp1_err, q[0].err);
          if (rsp1_ready) begin
            void'(q.pop_front());
            ptr_m = 0;
          end
        end
      end
    end
  end

  initial begin
    // Both requesters valid across reset release: port 0 must go first.
    set_req(0, OP_SUB, 32'd5, 32'd5);
    set_req(1, OP_OR, 32'h0000_00F0, 32'h0000_000F);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    drain(40);

    // Wrapping add on a single requester.
    set_req(0, OP_ADD, 32'hFFFF_FFFF, 32'd2);
    drain(20);

    // Illegal op code, then unsigned SLT.
    set_req(0, 4'b1111, W'($urandom), W'($urandom));
    drain(20);
    set_req(1, OP_SLT, 32'd1, 32'hFFFF_FFFF);
    drain(20);

    // Both continuously valid: grants must alternate.
    auto0 = 1'b1; auto1 = 1'b1; load_pct = 100;
    set_req(0, OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
    set_req(1, OP_ADD, 32'd7, 32'd9);
    repeat (12) cycle();
    auto0 = 1'b0; auto1 = 1'b0;
    drain(40);

    // Requester 1 stalls its response while requester 0 waits.
    rdy_pct1 = 0;
    rsp1_ready = 1'b0;
    set_req(1, OP_SUB, 32'd3, 32'd10);
    cycle();
    set_req(0, OP_OR, 32'h1234_0000, 32'h0000_5678);
    repeat (8) cycle();
    rdy_pct1 = 100;
    drain(40);

    // Reset while the op is in EXEC: it must never be reported.
    set_req(0, OP_ADD, 32'd100, 32'd23);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (5) cycle();
    drain(20);

    // Random traffic with random response back-pressure.
    auto0 = 1'b1; auto1 = 1'b1; load_pct = 30;
    rdy_pct0 = 60; rdy_pct1 = 60;
    repeat (400) cycle();
    auto0 = 1'b0; auto1 = 1'b0;
    rdy_pct0 = 100; rdy_pct1 = 100;
    drain(100);
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts requester N operation this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands A, B.
REQ-007 req0_ctrl / req1_ctrl  input  4  op code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
REQ-008 rsp0_valid / rsp1_valid  output  1  result for requester N available.
REQ-009 rsp0_ready / rsp1_ready  input  1  requester N consumes result.
REQ-010 rsp0_result / rsp1_result  output  WIDTH  ALU result.
REQ-011 rsp0_zero / rsp1_zero  output  1  result equals zero.
REQ-012 rsp0_err / rsp1_err  output  1  op code was not one of the five legal codes.

Function
REQ-013 The arbiter SHALL share one ALU between two requesters using FSM states IDLE, EXEC, RESP.
REQ-014 IDLE: reqN_ready SHALL equal grant to N, combinationally, only in IDLE; grant: single valid wins; both valid -> port named by priority pointer.
REQ-015 Handshake reqN_valid & reqN_ready SHALL register A, B, ctrl and grant owner; IDLE -> EXEC.
REQ-016 EXEC: registered operands SHALL be evaluated and result, zero, err latched into response registers; EXEC -> RESP unconditionally.
REQ-017 RESP: rspN_valid SHALL be high only for the owner, result/zero/err stable until rspN_ready; on rspN_valid & rspN_ready -> IDLE.
REQ-018 Latency: accept at edge T, rspN_valid high in cycle after edge T+2; max throughput one op per 3 cycles.
REQ-019 Priority pointer SHALL flip to the non-owner on every completed response handshake (round-robin); reset value port 0.
REQ-020 ADD/SUB SHALL wrap modulo 2^WIDTH; no carry/overflow output.
REQ-021 SLT SHALL compare unsigned; result 1 if A<B else 0, zero-extended to WIDTH.
REQ-022 zero SHALL be (result == 0) for every op, not only SUB.
REQ-023 Illegal op code: result 0, zero 1, err 1; response still delivered normally.
REQ-024 reqN_ready SHALL be 0 in EXEC and RESP; requests held valid while busy wait without loss.
REQ-025 Response for non-owner port SHALL keep rsp_valid 0; rspN_ready of non-owner ignored.
REQ-026 rspN_ready asserted in the first RESP cycle SHALL complete handshake that cycle (no bubble requirement beyond RESP state).

Reset
REQ-027 rst high at any edge SHALL force IDLE, pointer to port 0, all rsp*_valid/result/zero/err to 0, discarding any in-flight op.
REQ-028 req*_ready SHALL be 0 during the cycle rst is high.

Structure
REQ-029 Shared package SHALL hold op-code constants (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT) and FSM state encoding.
REQ-030 Combinational evaluation SHALL live in one sub-module alu_core (A, B, ctrl -> result, zero, err), no clock.

Verification
REQ-031 Single req0 ADD A=0xFFFFFFFF, B=2 -> rsp0_valid 2 cycles after accept, result 0x00000001, zero 0, err 0.
REQ-032 Both valid at reset exit, req0 SUB 5-5, req1 OR 0xF0|0x0F -> port0 served first (result 0, zero 1), then port1 (0xFF, zero 0).
REQ-033 Both continuously valid, 4 ops -> grants alternate 0,1,0,1.
REQ-034 rsp1_ready held low 5 cycles with req0 valid -> rsp1 result stable, req0_ready stays 0 until handshake.
REQ-035 Illegal ctrl 4'b1111 -> result 0, zero 1, err 1; SLT A=1, B=0xFFFFFFFF -> result 1.
REQ-036 rst asserted in EXEC -> next cycle IDLE, all rsp_valid 0, pending op never reported.
